rr_arbiter8: RTL and testbench
==============================

Name: rr_arbiter8

Overview:
- 8-requester round-robin arbiter that shares one downstream resource (bus, display, datapath slot) among eight request lines.
- Arbitration is fair round-robin: the search starts just above the last winner.
- Grant is held while the winner keeps requesting, with an optional hold limit.
- Outputs the one-hot grant, the encoded 3-bit winner index, and a 7-segment code of the winner for the board display.

Parameters:
- HOLD_MAX, 0: max consecutive cycles one grant may be held; 0 = unlimited; legal range 0..255.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  arbiter enable; 0 forces release and blocks new grants
- req  in  8  request lines; bit i = requester i
- gnt  out  8  one-hot grant, registered
- gnt_idx  out  3  index of granted requester, registered
- gnt_valid  out  1  1 while a grant is active
- HEX  out  7  active-low 7-segment code (segments g..a, bit6 = g)

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs and state clear immediately.
  - gnt=0, gnt_idx=0, gnt_valid=0.
  - Rotation pointer ptr=0, hold counter=0, state=IDLE.
  - HEX=7'b0111111 with ARB_HEX_EN, 7'b1111111 without.
- Reset asserted mid-grant drops the grant in the same instant; no completion cycle.
- FSM states: IDLE, GRANT.
- IDLE:
  - If en=1 and req!=0, pick the first set bit of req searching ptr, ptr+1, ..., ptr+7 (mod 8).
  - On the next rising edge: gnt=1<<w, gnt_idx=w, gnt_valid=1, hold counter=0, state goes to GRANT.
  - Latency is exactly 1 cycle from a sampled request to a visible grant.
  - If en=0 or req=0, stay in IDLE with outputs unchanged.
- GRANT: release when any of the following holds at the clock edge:
  - req[gnt_idx]=0;
  - en=0;
  - HOLD_MAX!=0 and hold counter==HOLD_MAX-1.
- Release action at that edge:
  - gnt=0, gnt_valid=0, gnt_idx keeps its last value.
  - ptr=(gnt_idx+1) mod 8, state goes to IDLE.
- Otherwise the hold counter increments; it saturates at 255 when HOLD_MAX=0.
- After any release there is exactly one IDLE cycle before the next grant. Other requesters never preempt an active grant.
- Wrap-around: ptr=7 searches 7,0,1,...,6; grant at idx 7 sets ptr=0.
- Simultaneous requests: only the round-robin winner is granted; the losers must keep their req asserted to be served.
- A requester that drops and reasserts req in the same cycle as its release is treated as a new request and ranks last behind the others.
- gnt is always one-hot or zero; gnt_valid=1 iff gnt!=0.

Optional Feature:
- Macro ARB_HEX_EN.
- Defined:
  - HEX is registered and updated at the same edge as gnt.
  - While gnt_valid=1, HEX shows digit gnt_idx: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
  - While gnt_valid=0, HEX shows dash 7'b0111111.
- Undefined: HEX is constant 7'b1111111 (blank) and no display logic is synthesized.

Test Plan:
- Reset: rst_n low mid-grant with req=8'h04 held → gnt=0, gnt_valid=0, HEX=0111111 asynchronously; after release, first grant goes to idx 2 (ptr=0).
- Single requester: en=1, req=8'h08 for 5 cycles then 0 → gnt=8'h08, gnt_idx=3, HEX=0110000 from cycle 1 to cycle 5; gnt=0 one cycle after req falls.
- Round robin: req=8'hFF held, HOLD_MAX=2 → grant sequence 0,1,...,7,0, each held 2 cycles, 1 idle cycle between grants.
- Wrap-around: grant idx 6 then release, req=8'h41 → next grant idx 0, not 6.
- Enable drop: active grant idx 5 with req held, en=0 → gnt=0 next edge; en=1 again with req=8'h20 → idx 5 re-granted after 1 cycle.
- Unlimited hold: HOLD_MAX=0, req=8'h03 held 300 cycles → idx 0 held all 300 cycles; idx 1 is never granted until req[0] drops.

Source files
------------

// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
// rr_arbiter8 : 8-way round-robin arbiter with grant hold and optional limit.
// Optional macro ARB_HEX_EN enables the registered 7-segment winner display.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter8 #(
    parameter int HOLD_MAX = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic [6:0] HEX
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam bit         c_limit_en  = (HOLD_MAX != 0);
    localparam logic [7:0] c_hold_last = (HOLD_MAX == 0) ? 8'hFF : 8'(HOLD_MAX - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_ptr;
    logic [2:0] w_ptr_nxt;
    logic [7:0] r_hold;
    logic [7:0] w_hold_nxt;
    logic [7:0] r_gnt;
    logic [7:0] w_gnt_nxt;
    logic [2:0] r_idx;
    logic [2:0] w_idx_nxt;
    logic       r_valid;
    logic       w_valid_nxt;

    logic       w_found;
    logic [2:0] w_win;
    logic [2:0] w_cand;
    logic       w_release;

    // Walk offsets from high to low so the closest requester above ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_cand  = r_ptr;
        for (int i = 7; i >= 0; i--) begin
            w_cand = r_ptr + 3'(i);
            if (req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_release = !req[r_idx] || !en || (c_limit_en && (r_hold == c_hold_last));

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold;
        w_gnt_nxt   = r_gnt;
        w_idx_nxt   = r_idx;
        w_valid_nxt = r_valid;
        case (r_state)
            ST_IDLE: begin
                if (en && w_found) begin
                    w_state_nxt = ST_GRANT;
                    w_gnt_nxt   = 8'b1 << w_win;
                    w_idx_nxt   = w_win;
                    w_valid_nxt = 1'b1;
                    w_hold_nxt  = 8'd0;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = 8'd0;
                    w_valid_nxt = 1'b0;
                    w_ptr_nxt   = r_idx + 3'd1;
                end else if (r_hold != 8'hFF) begin
                    w_hold_nxt = r_hold + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = 8'd0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= 3'd0;
            r_hold  <= 8'd0;
            r_gnt   <= 8'd0;
            r_idx   <= 3'd0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= w_hold_nxt;
            r_gnt   <= w_gnt_nxt;
            r_idx   <= w_idx_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_idx;
    assign gnt_valid = r_valid;

`ifdef ARB_HEX_EN
    logic [6:0] r_hex;
    logic [6:0] w_hex_nxt;

    // Active-low segments, bit6 = g; dash when no grant is active.
    always_comb begin
        w_hex_nxt = 7'b0111111;
        if (w_valid_nxt) begin
            case (w_idx_nxt)
                3'd0:    w_hex_nxt = 7'b1000000;
                3'd1:    w_hex_nxt = 7'b1111001;
                3'd2:    w_hex_nxt = 7'b0100100;
                3'd3:    w_hex_nxt = 7'b0110000;
                3'd4:    w_hex_nxt = 7'b0011001;
                3'd5:    w_hex_nxt = 7'b0010010;
                3'd6:    w_hex_nxt = 7'b0000010;
                default: w_hex_nxt = 7'b1111000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hex <= 7'b0111111;
        end else begin
            r_hex <= w_hex_nxt;
        end
    end

    assign HEX = r_hex;
`else
    assign HEX = 7'b1111111;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`default_nettype none
// ============================================================================
// tb_rr_arbiter8 : scoreboard bench for rr_arbiter8 (unlimited and HOLD_MAX=2).
// Revision: 1.0 - initial release
// ============================================================================
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] req_a, req_b;
    logic [7:0] gnt_a, gnt_b;
    logic [2:0] idx_a, idx_b;
    logic       val_a, val_b;
    logic [6:0] hex_a, hex_b;

    always #5 clk = ~clk;

    rr_arbiter8 #(.HOLD_MAX(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req_a),
        .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(val_a), .HEX(hex_a)
    );

    rr_arbiter8 #(.HOLD_MAX(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req_b),
        .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(val_b), .HEX(hex_b)
    );

    typedef struct {
        int idx;
        int len;
        int gap;   // idle cycles expected before this grant, -1 = don't care
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_cmp = 0;
    int   n_err = 0;

    bit   m_active[2] = '{1'b0, 1'b0};
    int   m_len[2]    = '{0, 0};
    int   m_idle[2]   = '{0, 0};
    exp_t m_exp[2];

    function automatic logic [6:0] exp_hex(input int idx, input bit valid);
        logic [6:0] h;
        h = 7'h7F;
`ifdef ARB_HEX_EN
        if (!valid) h = 7'h3F;
        else begin
            case (idx)
                0: h = 7'h40;
                1: h = 7'h79;
                2: h = 7'h24;
                3: h = 7'h30;
                4: h = 7'h19;
                5: h = 7'h12;
                6: h = 7'h02;
                default: h = 7'h78;
            endcase
        end
`endif
        return h;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, expv, expv);
        end
    endtask

    task automatic push(input int d, input int idx, input int len, input int gap);
        exp_t e;
        e.idx = idx;
        e.len = len;
        e.gap = gap;
        if (d == 0) q_a.push_back(e);
        else        q_b.push_back(e);
    endtask

    task automatic mon_step(input int d, input logic [7:0] g, input logic [2:0] ix,
                            input logic v, input logic [6:0] hx);
        exp_t e;
        bit   empty;
        if (v) begin
            if (!m_active[d]) begin
                empty = (d == 0) ? (q_a.size() == 0) : (q_b.size() == 0);
                if (empty) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_grant dut%0d: got idx %0d, required no grant", d, ix);
                    e.idx = int'(ix);
                    e.len = -1;
                    e.gap = -1;
                end else begin
                    if (d == 0) e = q_a.pop_front();
                    else        e = q_b.pop_front();
                    check($sformatf("grant_idx dut%0d", d), int'(ix), e.idx);
                    check($sformatf("grant_onehot dut%0d", d), int'(g), 1 << e.idx);
                    check($sformatf("grant_hex dut%0d", d), int'(hx), int'(exp_hex(e.idx, 1'b1)));
                    if (e.gap >= 0)
                        check($sformatf("idle_gap dut%0d", d), m_idle[d], e.gap);
                end
                m_exp[d]    = e;
                m_active[d] = 1'b1;
                m_len[d]    = 1;
            end else begin
                m_len[d]++;
                check($sformatf("held_idx dut%0d", d), int'(ix), m_exp[d].idx);
            end
        end else begin
            if (m_active[d]) begin
                if (m_exp[d].len >= 0)
                    check($sformatf("hold_len dut%0d idx%0d", d, m_exp[d].idx), m_len[d], m_exp[d].len);
                check($sformatf("released_gnt dut%0d", d), int'(g), 0);
                check($sformatf("released_hex dut%0d", d), int'(hx), int'(exp_hex(0, 1'b0)));
                m_active[d] = 1'b0;
                m_idle[d]   = 1;
            end else begin
                m_idle[d]++;
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        mon_step(0, gnt_a, idx_a, val_a, hex_a);
        mon_step(1, gnt_b, idx_b, val_b, hex_b);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        req_a = 8'h00;
        req_b = 8'h00;
        cyc(2);
        check("reset_gnt", int'(gnt_a), 0);
        check("reset_valid", int'(val_a), 0);
        check("reset_idx", int'(idx_a), 0);
        check("reset_hex", int'(hex_a), int'(exp_hex(0, 1'b0)));
        check("reset_gnt_b", int'(gnt_b), 0);
        rst_n = 1'b1;
        en    = 1'b1;
        cyc(1);

        // Move ptr to 3, then reset mid-grant and confirm ptr returns to 0.
        req_a = 8'h04; push(0, 2, 2, -1);
        cyc(2);
        req_a = 8'h00;
        cyc(1);
        req_a = 8'h04; push(0, 2, 3, 1);
        cyc(3);
        rst_n = 1'b0;
        req_a = 8'h24;
        #1;
        check("async_reset_gnt", int'(gnt_a), 0);
        check("async_reset_valid", int'(val_a), 0);
        check("async_reset_hex", int'(hex_a), int'(exp_hex(0, 1'b0)));
        push(0, 2, 2, -1);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        check("post_reset_latency_valid", int'(val_a), 1);
        check("post_reset_idx", int'(idx_a), 2);
        cyc(1);
        req_a = 8'h00;
        cyc(2);

        // Single requester held 5 cycles.
        req_a = 8'h08; push(0, 3, 5, -1);
        cyc(1);
        check("single_gnt", int'(gnt_a), 8'h08);
        check("single_idx", int'(idx_a), 3);
        check("single_hex", int'(hex_a), int'(exp_hex(3, 1'b1)));
        cyc(4);
        req_a = 8'h00;
        cyc(1);
        check("single_release_valid", int'(val_a), 0);
        check("single_release_gnt", int'(gnt_a), 0);
        check("single_release_idx_kept", int'(idx_a), 3);
        cyc(1);

        // Wrap-around: release idx 6 leaves ptr=7, so 0 beats 6.
        req_a = 8'h40; push(0, 6, 2, -1);
        cyc(2);
        req_a = 8'h00;
        cyc(1);
        req_a = 8'h41; push(0, 0, 3, 1);
        cyc(3);
        req_a = 8'h00;
        cyc(2);

        // Enable drop and re-enable on idx 5, then en=0 blocks new grants.
        req_a = 8'h20; push(0, 5, 2, -1);
        cyc(2);
        en = 1'b0;
        cyc(1);
        check("en_drop_gnt", int'(gnt_a), 0);
        en = 1'b1; push(0, 5, 3, 1);
        cyc(1);
        check("en_regrant_valid", int'(val_a), 1);
        check("en_regrant_idx", int'(idx_a), 5);
        cyc(2);
        en = 1'b0;
        cyc(3);
        check("en_low_blocks_grant", int'(val_a), 0);
        req_a = 8'h00;
        en    = 1'b1;
        cyc(2);

        // Unlimited hold: idx 0 keeps the grant past hold-counter saturation.
        req_a = 8'h03; push(0, 0, 300, -1);
        cyc(300);
        req_a = 8'h02; push(0, 1, 2, 1);
        cyc(3);
        req_a = 8'h00;
        cyc(2);

        // HOLD_MAX=2 round robin with all requesters active.
        req_b = 8'hFF;
        for (int i = 0; i < 9; i++) push(1, i % 8, 2, (i == 0) ? -1 : 1);
        cyc(27);
        req_b = 8'h00;
        cyc(5);

        check("queue_a_drained", q_a.size(), 0);
        check("queue_b_drained", q_b.size(), 0);
        check("no_open_grant_a", int'(m_active[0]), 0);
        check("no_open_grant_b", int'(m_active[1]), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
